flash_wb_bridge: RTL



---
 rtl/flash_wb_pkg.sv | 20 ++
 rtl/flash_wb_cache.sv | 46 ++++
 rtl/flash_wb_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/flash_wb_pkg.sv
// Shared types and constants for the Wishbone-to-NOR-flash read bridge.
// The optional single-word read cache is selected with FLASH_WB_CACHE_EN.
package flash_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam int CNT_W    = 4;
  localparam int FLASH_AW = 22;

  // Zero the byte lanes the master did not select.
  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] sel);
    return {sel[1] ? d[15:8] : 8'h00, sel[0] ? d[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/flash_wb_cache.sv
// Single-word read cache: one tag, one data word, one valid bit per byte.
// Only instantiated when FLASH_WB_CACHE_EN is defined.
module flash_wb_cache
  import flash_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] lookup_adr,
  input  logic [1:0]  lookup_sel,
  output logic        hit,
  output logic [15:0] rd_data,
  input  logic        miss_start,
  input  logic [1:0]  fill_en,
  input  logic [7:0]  fill_byte
);

  logic [20:0] tag;
  logic [15:0] data;
  logic [1:0]  valid;

  assign hit     = (tag == lookup_adr) && (lookup_sel != 2'b00) &&
                   ((lookup_sel & ~valid) == 2'b00);
  assign rd_data = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 2'b00;
    end else if (miss_start && (tag != lookup_adr)) begin
      // A different word evicts everything before its bytes arrive.
      tag   <= lookup_adr;
      valid <= 2'b00;
    end else begin
      if (fill_en[0]) begin
        data[7:0] <= fill_byte;
        valid[0]  <= 1'b1;
      end
      if (fill_en[1]) begin
        data[15:8] <= fill_byte;
        valid[1]   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_wb_bridge.sv
// Wishbone slave turning 16-bit word reads into one or two timed 8-bit NOR
// flash reads; writes are acknowledged and dropped. Cache: FLASH_WB_CACHE_EN.
module flash_wb_bridge
  import flash_wb_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [20:0]         wb_adr_i,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  input  logic [1:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  output logic [FLASH_AW-1:0] flash_addr_,
  input  logic [7:0]          flash_data_,
  output logic                flash_oe_n_,
  output logic                flash_we_n_,
  output logic                flash_rst_n_,
  output logic [1:0]          dbg_state
);

  // Handshake: a request is taken only in IDLE while cyc & stb are high;
  // wb_ack_o is high for exactly one cycle and the master may drop stb after
  // seeing it; a request is never accepted during the ACK cycle itself.

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [20:0]      adr_q;
  logic [1:0]       sel_q;
  logic [7:0]       lo_q;
  logic             abort_q;
  logic             abort_next;
  logic             cache_hit;
  logic [15:0]      cache_data;
  logic             unused_dat;

  assign flash_we_n_  = 1'b1;
  assign flash_rst_n_ = 1'b1;
  assign dbg_state    = state;
  assign unused_dat   = ^wb_dat_i;
  assign abort_next   = abort_q | ~wb_cyc_i;

`ifdef FLASH_WB_CACHE_EN
  logic       miss_start;
  logic [1:0] fill_en;

  assign miss_start = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_we_i &&
                      (wb_sel_i != 2'b00) && !cache_hit;
  assign fill_en    = {(state == HI) && (cnt == '0), (state == LO) && (cnt == '0)};

  flash_wb_cache u_cache (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .lookup_adr (wb_adr_i),
    .lookup_sel (wb_sel_i),
    .hit        (cache_hit),
    .rd_data    (cache_data),
    .miss_start (miss_start),
    .fill_en    (fill_en),
    .fill_byte  (flash_data_)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 16'h0000;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      adr_q       <= '0;
      sel_q       <= 2'b00;
      lo_q        <= 8'h00;
      abort_q     <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 16'h0000;
      flash_addr_ <= '0;
      flash_oe_n_ <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          abort_q  <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            adr_q <= wb_adr_i;
            sel_q <= wb_sel_i;
            cnt   <= WAIT_LD;
            if (wb_we_i || (wb_sel_i == 2'b00)) begin
              state    <= ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= 16'h0000;
            end else if (cache_hit) begin
              state    <= ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= lane_mask(cache_data, wb_sel_i);
            end else if (wb_sel_i[0]) begin
              state       <= LO;
              flash_addr_ <= {wb_adr_i, 1'b0};
              flash_oe_n_ <= 1'b0;
            end else begin
              state       <= HI;
              flash_addr_ <= {wb_adr_i, 1'b1};
              flash_oe_n_ <= 1'b0;
            end
          end
        end

        LO: begin
          abort_q <= abort_next;
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            lo_q <= flash_data_;
            if (sel_q[1]) begin
              // oe stays low; only the address moves to the odd byte.
              state       <= HI;
              flash_addr_ <= {adr_q, 1'b1};
              cnt         <= WAIT_LD;
            end else begin
              flash_oe_n_ <= 1'b1;
              wb_dat_o    <= {8'h00, flash_data_};
              state       <= abort_next ? IDLE : ACK;
              wb_ack_o    <= ~abort_next;
            end
          end
        end

        HI: begin
          abort_q <= abort_next;
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            flash_oe_n_ <= 1'b1;
            wb_dat_o    <= {flash_data_, sel_q[0] ? lo_q : 8'h00};
            state       <= abort_next ? IDLE : ACK;
            wb_ack_o    <= ~abort_next;
          end
        end

        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state       <= IDLE;
          wb_ack_o    <= 1'b0;
          flash_oe_n_ <= 1'b1;
        end
      endcase
    end
  end

endmodule
